// File: rtl/wire_share_arbiter.sv
// rtl/wire_share_arbiter.sv - round-robin owner arbiter driving the shared 4:1 wire mux selects
module wire_share_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       s1,
  output logic       s0,
  output logic       busy
);

  localparam int CW = $clog2(MAX_HOLD);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    own_q, own_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [1:0]    sel_q, sel_d;

  logic [3:0]    req_oth;
  logic [2:0]    pick_all, pick_oth;

  // Returns {found, index}; lowest offset from p wins, wrapping 3->0.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  assign req_oth  = req & ~(4'b0001 << own_q);
  assign pick_all = rr_pick(req, ptr_q);
  assign pick_oth = rr_pick(req_oth, ptr_q);

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (pick_all[2]) begin
          state_d = GRANT;
          own_d   = pick_all[1:0];
          ptr_d   = pick_all[1:0] + 2'd1;
          cnt_d   = '0;
          gnt_d   = 4'b0001 << pick_all[1:0];
          sel_d   = pick_all[1:0];
        end
      end
      GRANT: begin
        if (req[own_q] && (cnt_q < CNT_LAST)) begin
          cnt_d = cnt_q + CW'(1);
        end else if (req[own_q] && (req_oth == 4'b0000)) begin
          // Sole requester keeps the wire; restart the hold window.
          cnt_d = '0;
        end else if (pick_oth[2]) begin
          own_d = pick_oth[1:0];
          ptr_d = pick_oth[1:0] + 2'd1;
          cnt_d = '0;
          gnt_d = 4'b0001 << pick_oth[1:0];
          sel_d = pick_oth[1:0];
        end else begin
          state_d = IDLE;
          own_d   = 2'd0;
          cnt_d   = '0;
          gnt_d   = 4'b0000;
          sel_d   = 2'b00;
        end
      end
      default: begin
        state_d = IDLE;
        own_d   = 2'd0;
        cnt_d   = '0;
        gnt_d   = 4'b0000;
        sel_d   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      own_q   <= 2'd0;
      ptr_q   <= 2'd0;
      cnt_q   <= '0;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
    end
  end

  assign gnt  = gnt_q;
  assign s1   = sel_q[1];
  assign s0   = sel_q[0];
  assign busy = |gnt_q;

endmodule

// File: tb/tb_wire_share_arbiter.sv
// tb/tb_wire_share_arbiter.sv - directed self-checking bench for wire_share_arbiter with MAX_HOLD=4
module tb_wire_share_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       s1;
  logic       s0;
  logic       busy;

  int errors = 0;
  int checks = 0;

  wire_share_arbiter #(.MAX_HOLD(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .gnt  (gnt),
    .s1   (s1),
    .s0   (s0),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // exp_gnt is the one-hot grant; select and busy follow from it.
  task automatic check(input string tag, input logic [3:0] exp_gnt, input logic [1:0] exp_sel);
    logic exp_busy;
    exp_busy = |exp_gnt;
    checks++;
    assert (gnt === exp_gnt) else begin
      errors++;
      $error("FAIL %s gnt: got %b expected %b", tag, gnt, exp_gnt);
    end
    checks++;
    assert ({s1, s0} === exp_sel) else begin
      errors++;
      $error("FAIL %s s1s0: got %b expected %b", tag, {s1, s0}, exp_sel);
    end
    checks++;
    assert (busy === exp_busy) else begin
      errors++;
      $error("FAIL %s busy: got %b expected %b", tag, busy, exp_busy);
    end
  endtask

  initial begin
    logic [1:0] idx;
    rst = 1'b1;
    req = 4'b1111;
    #12;
    check("reset_hold", 4'b0000, 2'b00);

    // Rotation with all requesting: each owner exactly 4 cycles.
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int e = 1; e <= 17; e++) begin
      tick();
      idx = 2'(((e - 1) / 4) % 4);
      check($sformatf("rotate_e%0d", e), 4'b0001 << idx, idx);
    end

    req = 4'b0000;
    tick();
    check("release_idle", 4'b0000, 2'b00);
    tick();
    check("stay_idle", 4'b0000, 2'b00);

    // Single requester with no bubble at expiry.
    req = 4'b0100;
    for (int c = 0; c < 20; c++) begin
      tick();
      check($sformatf("single_c%0d", c), 4'b0100, 2'b10);
    end
    req = 4'b0000;
    tick();
    check("single_drop", 4'b0000, 2'b00);

    // Early release and same-edge handoff 1 -> 3 (ptr now 3).
    req = 4'b0010;
    tick();
    check("early_own1_a", 4'b0010, 2'b01);
    req = 4'b1010;
    tick();
    check("early_own1_b", 4'b0010, 2'b01);
    req = 4'b1000;
    tick();
    check("handoff_to3", 4'b1000, 2'b11);
    req = 4'b0011;
    tick();
    check("ptr0_grant0", 4'b0001, 2'b00);

    // Owner 3 expires with req=1001; scan wraps to 0.
    req = 4'b1000;
    tick();
    check("wrap_own3_c0", 4'b1000, 2'b11);
    req = 4'b1001;
    for (int c = 1; c <= 3; c++) begin
      tick();
      check($sformatf("wrap_own3_c%0d", c), 4'b1000, 2'b11);
    end
    tick();
    check("wrap_to0", 4'b0001, 2'b00);

    // Async reset between edges while owner 2 holds.
    req = 4'b0100;
    tick();
    check("pre_rst_own2", 4'b0100, 2'b10);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst", 4'b0000, 2'b00);
    req = 4'b0110;
    @(posedge clk);
    #1;
    check("rst_held_edge", 4'b0000, 2'b00);
    rst = 1'b0;
    tick();
    check("post_rst_ptr0", 4'b0010, 2'b01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
